// File: rtl/sipo_frame_unit.sv
// Serial-to-parallel frame collector: gathers 1..WIDTH qualified bits per frame
// in LSB- or MSB-first order and hands each word out through a one-entry valid/ready holding register.
module sipo_frame_unit #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned LW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             bit_valid,
  input  logic [LW-1:0]    frame_len,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy,
  output logic [LW-1:0]    bit_count
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    len_q, len_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic [LW-1:0]    len_sel;
  logic [LW-1:0]    len_eff;
  logic [LW-1:0]    cnt_inc;
  logic [LW-1:0]    idx;
  logic [WIDTH-1:0] word;
  logic             frame_done;

  // Next-state: length latch, bit placement, completion and the output handshake
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    frame_done  = 1'b0;

    // Out-of-range lengths collapse to a full-width frame
    len_sel = (frame_len == '0 || frame_len > LW'(WIDTH)) ? LW'(WIDTH) : frame_len;
    len_eff = (cnt_q == '0) ? len_sel : len_q;
    cnt_inc = cnt_q + LW'(1);
    idx     = MSB_FIRST ? LW'(len_eff - cnt_inc) : cnt_q;
    // Bits are written in place; a fresh frame starts from zero so unused upper bits stay 0
    word    = ((cnt_q == '0) ? '0 : shreg_q) | (WIDTH'(data_in) << idx);

    if (clear) begin
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (bit_valid) begin
      len_d   = len_eff;
      shreg_d = word;
      if (cnt_inc == len_eff) begin
        cnt_d      = '0;
        frame_done = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end

    if (frame_done) begin
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_data_d  = word;
        out_valid_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign bit_count = cnt_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_frame_unit.sv
// Bench for sipo_frame_unit: LSB-first and MSB-first instances share stimulus and are
// checked every cycle against a queue-based frame model, plus directed known-answer checks.
module tb_sipo_frame_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             data_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic [LW-1:0]    frame_len = LW'(8);
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;

  logic [WIDTH-1:0] l_data, m_data;
  logic             l_valid, m_valid, l_ovr, m_ovr, l_busy, m_busy;
  logic [LW-1:0]    l_cnt, m_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sipo_frame_unit #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .bit_valid(bit_valid),
    .frame_len(frame_len), .clear(clear), .out_data(l_data), .out_valid(l_valid),
    .out_ready(out_ready), .overrun(l_ovr), .busy(l_busy), .bit_count(l_cnt)
  );

  sipo_frame_unit #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .bit_valid(bit_valid),
    .frame_len(frame_len), .clear(clear), .out_data(m_data), .out_valid(m_valid),
    .out_ready(out_ready), .overrun(m_ovr), .busy(m_busy), .bit_count(m_cnt)
  );

  // Reference model: current frame as a list of received bits
  int          bits_q[$];
  int          m_len;
  logic [7:0]  held_l, held_m;
  logic        mvalid, movr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    bit         done;
    logic [7:0] wl, wm;
    done = 0;
    wl   = '0;
    wm   = '0;
    if (!reset) begin
      bits_q.delete();
      m_len  = 0;
      held_l = '0;
      held_m = '0;
      mvalid = 0;
      movr   = 0;
    end else begin
      if (clear) begin
        bits_q.delete();
        movr = 0;
      end else if (bit_valid) begin
        if (bits_q.size() == 0)
          m_len = (int'(frame_len) == 0 || int'(frame_len) > 8) ? 8 : int'(frame_len);
        bits_q.push_back(int'(data_in));
        if (bits_q.size() == m_len) begin
          for (int k = 0; k < m_len; k++) begin
            wl[k]           = bits_q[k][0];
            wm[m_len-1-k]   = bits_q[k][0];
          end
          done = 1;
          bits_q.delete();
        end
      end
      if (done) begin
        if (mvalid && !out_ready) movr = 1;
        else begin
          held_l = wl;
          held_m = wm;
          mvalid = 1;
        end
      end else if (mvalid && out_ready) begin
        mvalid = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("l_data",  32'(l_data),  32'(held_l));
    check("m_data",  32'(m_data),  32'(held_m));
    check("l_valid", 32'(l_valid), 32'(mvalid));
    check("m_valid", 32'(m_valid), 32'(mvalid));
    check("l_ovr",   32'(l_ovr),   32'(movr));
    check("m_ovr",   32'(m_ovr),   32'(movr));
    check("l_cnt",   32'(l_cnt),   32'(bits_q.size()));
    check("m_cnt",   32'(m_cnt),   32'(bits_q.size()));
    check("l_busy",  32'(l_busy),  32'(bits_q.size() != 0));
    check("m_busy",  32'(m_busy),  32'(bits_q.size() != 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic send(input logic d);
    bit_valid = 1'b1;
    data_in   = d;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int n);
    for (int k = 0; k < n; k++) send(w[k]);
  endtask

  initial begin
    logic [7:0] w;
    // Reset
    tick();
    tick();
    check("rst_valid", 32'(l_valid), 32'd0);
    check("rst_data",  32'(m_data),  32'd0);
    reset = 1'b1;
    tick();

    // Full 8-bit frame, both orders
    out_ready = 1'b1;
    frame_len = LW'(8);
    send_word(8'h4D, 8);
    check("lsb_4d", 32'(l_data), 32'h4D);
    check("msb_b2", 32'(m_data), 32'hB2);
    check("v_after", 32'(l_valid), 32'd1);
    tick();
    check("v_fall", 32'(l_valid), 32'd0);

    // Short frame, upper bits zero
    frame_len = LW'(5);
    w = 8'b0001_0011;
    send_word(w, 5);
    check("msb_19", 32'(m_data), 32'h19);
    tick();

    // Overrun: second frame dropped while first is held
    out_ready = 1'b0;
    frame_len = LW'(8);
    send_word(8'hA5, 8);
    send_word(8'h3C, 8);
    check("ovr_hold", 32'(l_data), 32'hA5);
    check("ovr_set",  32'(l_ovr),  32'd1);
    out_ready = 1'b1;
    tick();
    check("ovr_consumed", 32'(l_valid), 32'd0);
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("ovr_clear", 32'(l_ovr), 32'd0);

    // Completion coincident with consume
    send_word(8'h11, 8);
    send_word(8'h22, 7);
    out_ready = 1'b1;
    send(1'b0);
    check("sim_data",  32'(l_data),  32'h22);
    check("sim_valid", 32'(l_valid), 32'd1);
    check("sim_ovr",   32'(l_ovr),   32'd0);
    tick();

    // clear together with bit_valid discards the bit
    send_word(8'h07, 3);
    clear = 1'b1;
    send(1'b1);
    clear = 1'b0;
    check("clr_cnt",  32'(l_cnt),  32'd0);
    check("clr_busy", 32'(l_busy), 32'd0);
    send_word(8'h5A, 8);
    check("clean_5a", 32'(l_data), 32'h5A);

    // Mid-frame reset
    send_word(8'hFF, 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_cnt",   32'(l_cnt),   32'd0);
    check("mrst_valid", 32'(l_valid), 32'd0);
    check("mrst_data",  32'(l_data),  32'd0);
    tick();

    // Out-of-range lengths and mid-frame length change
    frame_len = LW'(0);
    send_word(8'hC3, 8);
    check("len0", 32'(l_data), 32'hC3);
    frame_len = LW'(9);
    send_word(8'h96, 8);
    check("len9", 32'(l_data), 32'h96);
    frame_len = LW'(8);
    send_word(8'hE1, 2);
    frame_len = LW'(4);
    for (int k = 2; k < 4; k++) send(w[k]);
    check("len_chg_mid", 32'(l_cnt), 32'd4);
    frame_len = LW'(4);
    w = 8'hE1;
    for (int k = 4; k < 8; k++) send(w[k]);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit_valid = ($urandom_range(0, 99) < 50);
      data_in   = 1'($urandom);
      frame_len = LW'($urandom_range(0, 15));
      clear     = ($urandom_range(0, 99) < 3);
      out_ready = ($urandom_range(0, 99) < 60);
      reset     = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
